// File: rtl/riscv_dift_tag_policy_unit.sv
// DIFT tag policy unit for the RI5CY EX stage.
// Holds per-class propagation modes and check enables, registers the
// propagated result tag one cycle after each EX op, raises a held trap
// request on a policy violation and counts violations.
// Optional feature: define DIFT_VIOLATION_LOG_EN to add a FIFO of violation
// PCs that software pops through config address 3.
module riscv_dift_tag_policy_unit #(
    parameter int TAG_W     = 1,
    parameter int N_CLASS   = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we_i,
    input  logic                       cfg_re_i,
    input  logic [1:0]                 cfg_addr_i,
    input  logic [31:0]                cfg_wdata_i,
    output logic [31:0]                cfg_rdata_o,
    input  logic                       ex_valid_i,
    input  logic [$clog2(N_CLASS)-1:0] ex_class_i,
    input  logic [TAG_W-1:0]           tag_a_i,
    input  logic [TAG_W-1:0]           tag_b_i,
    input  logic [TAG_W-1:0]           tag_d_i,
    input  logic [31:0]                ex_pc_i,
    output logic [TAG_W-1:0]           tag_res_o,
    output logic                       tag_res_valid_o,
    output logic                       exc_req_o,
    output logic [31:0]                exc_pc_o,
    input  logic                       exc_ack_i
);

    localparam int CLS_W  = $clog2(N_CLASS);
    localparam int PROP_W = 2 * N_CLASS;
    localparam int CHK_W  = 3 * N_CLASS;

    typedef enum logic {
        TRAP_IDLE = 1'b0,
        TRAP_PEND = 1'b1
    } trap_state_e;

    logic [PROP_W-1:0] prop_q, prop_d;
    logic [CHK_W-1:0]  check_q, check_d;
    logic [1:0]        mode;
    logic [2:0]        chk;
    logic [TAG_W-1:0]  tag_calc;
    logic              violation;
    logic              clear_cnt;
    logic [TAG_W-1:0]  tag_res_q, tag_res_d;
    logic              tag_valid_q, tag_valid_d;
    trap_state_e       state_q, state_d;
    logic [31:0]       exc_pc_q, exc_pc_d;
    logic [31:0]       count_rd;
    logic [31:0]       log_head;
    logic              unused_wdata;

    // Wide write data only partly maps onto the policy registers.
    assign unused_wdata = ^cfg_wdata_i;
    assign clear_cnt    = cfg_we_i && (cfg_addr_i == 2'd2);

    // Policy register updates; bits above the implemented width are dropped.
    always_comb begin
        prop_d  = prop_q;
        check_d = check_q;
        if (cfg_we_i && (cfg_addr_i == 2'd0)) prop_d  = cfg_wdata_i[PROP_W-1:0];
        if (cfg_we_i && (cfg_addr_i == 2'd1)) check_d = cfg_wdata_i[CHK_W-1:0];
    end

    // Policy registers; every class starts in OR mode with checks off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prop_q  <= {N_CLASS{2'b10}};
            check_q <= '0;
        end else begin
            prop_q  <= prop_d;
            check_q <= check_d;
        end
    end

    // Pick the class fields; unknown class codes fall back to class 0.
    always_comb begin
        mode = prop_q[1:0];
        chk  = check_q[2:0];
        for (int c = 1; c < N_CLASS; c++) begin
            if (ex_class_i == CLS_W'(c)) begin
                mode = prop_q[2*c +: 2];
                chk  = check_q[3*c +: 3];
            end
        end
    end

    // Tag propagation and violation detection for the current op.
    always_comb begin
        unique case (mode)
            2'b00:   tag_calc = tag_d_i;
            2'b01:   tag_calc = tag_a_i & tag_b_i;
            2'b10:   tag_calc = tag_a_i | tag_b_i;
            default: tag_calc = '0;
        endcase
        violation = ex_valid_i & ((chk[0] & (|tag_a_i)) |
                                  (chk[1] & (|tag_b_i)) |
                                  (chk[2] & (|tag_d_i)));
    end

    // Result tag holds its last value; the valid flag tracks ex_valid_i.
    always_comb begin
        tag_res_d   = ex_valid_i ? tag_calc : tag_res_q;
        tag_valid_d = ex_valid_i;
    end

    // One-cycle result pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_res_q   <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            tag_res_q   <= tag_res_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    assign tag_res_o       = tag_res_q;
    assign tag_res_valid_o = tag_valid_q;

    // Trap state and captured PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TRAP_IDLE;
            exc_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            exc_pc_q <= exc_pc_d;
        end
    end

    // Trap next state: first violation wins unless the pending one is acked.
    always_comb begin
        state_d  = state_q;
        exc_pc_d = exc_pc_q;
        unique case (state_q)
            TRAP_IDLE: if (violation) state_d = TRAP_PEND;
            TRAP_PEND: if (exc_ack_i && !violation) state_d = TRAP_IDLE;
            default:   state_d = TRAP_IDLE;
        endcase
        if (violation && ((state_q == TRAP_IDLE) || exc_ack_i)) exc_pc_d = ex_pc_i;
    end

    // Trap outputs.
    always_comb begin
        exc_req_o = (state_q == TRAP_PEND);
        exc_pc_o  = exc_pc_q;
    end

`ifdef DIFT_VIOLATION_LOG_EN
    localparam int LOG_W = $clog2(LOG_DEPTH);

    logic [31:0]    log_mem_q [LOG_DEPTH];
    logic [LOG_W:0] rd_ptr_q, wr_ptr_q;
    logic           ovf_q;
    logic [30:0]    cnt_q;
    logic           log_empty, log_full, log_pop, log_push;

    assign log_empty = (rd_ptr_q == wr_ptr_q);
    assign log_full  = (rd_ptr_q[LOG_W] != wr_ptr_q[LOG_W]) &&
                       (rd_ptr_q[LOG_W-1:0] == wr_ptr_q[LOG_W-1:0]);
    assign log_pop   = cfg_re_i && (cfg_addr_i == 2'd3) && !log_empty;
    assign log_push  = violation && (!log_full || log_pop) && !clear_cnt;

    // Log pointers, overflow flag and 31-bit saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (clear_cnt) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (log_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (log_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (violation && log_full && !log_pop) ovf_q <= 1'b1;
            if (violation && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Log storage; contents only matter between the pointers.
    always_ff @(posedge clk) begin
        if (log_push) log_mem_q[wr_ptr_q[LOG_W-1:0]] <= ex_pc_i;
    end

    assign count_rd = {ovf_q, cnt_q};
    assign log_head = log_empty ? 32'h0 : log_mem_q[rd_ptr_q[LOG_W-1:0]];
`else
    logic [31:0] cnt_q;
    logic        unused_log;

    // Without the log, pops do nothing and the depth is irrelevant.
    assign unused_log = cfg_re_i & (LOG_DEPTH > 0);

    // 32-bit saturating violation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_cnt) begin
            cnt_q <= '0;
        end else if (violation && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_rd = cnt_q;
    assign log_head = 32'h0;
`endif

    // Combinational config read mux.
    always_comb begin
        unique case (cfg_addr_i)
            2'd0:    cfg_rdata_o = 32'(prop_q);
            2'd1:    cfg_rdata_o = 32'(check_q);
            2'd2:    cfg_rdata_o = count_rd;
            default: cfg_rdata_o = log_head;
        endcase
    end

endmodule

// File: tb/tb_riscv_dift_tag_policy_unit.sv
// Self-checking bench for riscv_dift_tag_policy_unit (TAG_W=1 main instance
// plus a TAG_W=4 instance for wide-tag propagation). Expected result tags are
// computed from a bench-side policy model and queued until the DUT responds.
module tb_riscv_dift_tag_policy_unit;

    logic        clk;
    logic        rst_n;
    logic        cfg_we, cfg_re;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata, cfg_rdata4;
    logic        ex_valid;
    logic [2:0]  ex_class;
    logic        tag_a, tag_b, tag_d;
    logic [3:0]  tag4_a, tag4_b, tag4_d;
    logic [31:0] ex_pc;
    logic        tag_res, tag_res_valid;
    logic [3:0]  tag_res4;
    logic        tag_res_valid4;
    logic        exc_req, exc_req4;
    logic [31:0] exc_pc, exc_pc4;
    logic        exc_ack;

    int          checks;
    int          errors;
    logic        expQ[$];
    logic [15:0] propModel;
    logic        expTag;

    riscv_dift_tag_policy_unit #(.TAG_W(1), .N_CLASS(8), .LOG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we_i(cfg_we), .cfg_re_i(cfg_re), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
        .ex_valid_i(ex_valid), .ex_class_i(ex_class),
        .tag_a_i(tag_a), .tag_b_i(tag_b), .tag_d_i(tag_d), .ex_pc_i(ex_pc),
        .tag_res_o(tag_res), .tag_res_valid_o(tag_res_valid),
        .exc_req_o(exc_req), .exc_pc_o(exc_pc), .exc_ack_i(exc_ack)
    );

    riscv_dift_tag_policy_unit #(.TAG_W(4), .N_CLASS(8), .LOG_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we_i(cfg_we), .cfg_re_i(cfg_re), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata4),
        .ex_valid_i(ex_valid), .ex_class_i(ex_class),
        .tag_a_i(tag4_a), .tag_b_i(tag4_b), .tag_d_i(tag4_d), .ex_pc_i(ex_pc),
        .tag_res_o(tag_res4), .tag_res_valid_o(tag_res_valid4),
        .exc_req_o(exc_req4), .exc_pc_o(exc_pc4), .exc_ack_i(exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference propagation for a 1-bit tag under the modelled policy.
    function automatic logic modelTag(input int cls, input logic a, input logic b, input logic d);
        logic [1:0] m;
        m = propModel[2*cls +: 2];
        case (m)
            2'b00:   return d;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one EX op and queue its expected result tag.
    task automatic applyStimulus(input int cls, input logic a, input logic b, input logic d, input logic [31:0] pc);
        ex_valid = 1'b1;
        ex_class = 3'(cls);
        tag_a    = a;
        tag_b    = b;
        tag_d    = d;
        ex_pc    = pc;
        expQ.push_back(modelTag(cls, a, b, d));
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] expected);
        cfg_addr = addr;
        #1;
        checkOutput(tag, cfg_rdata, expected);
    endtask

    // Advance one clock, score the result pipeline, update the model, idle inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            expTag = expQ.pop_front();
            checkOutput("tag_res", 32'(tag_res), 32'(expTag));
            checkOutput("tag_res_valid", 32'(tag_res_valid), 32'd1);
        end else begin
            checkOutput("tag_res_valid_idle", 32'(tag_res_valid), 32'd0);
        end
        if (cfg_we && (cfg_addr == 2'd0)) propModel = cfg_wdata[15:0];
        cfg_we   = 1'b0;
        cfg_re   = 1'b0;
        exc_ack  = 1'b0;
        ex_valid = 1'b0;
        tag_a = 1'b0; tag_b = 1'b0; tag_d = 1'b0;
        tag4_a = '0; tag4_b = '0; tag4_d = '0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        ex_valid = 1'b0; ex_class = '0; ex_pc = '0; exc_ack = 1'b0;
        tag_a = 1'b0; tag_b = 1'b0; tag_d = 1'b0;
        tag4_a = '0; tag4_b = '0; tag4_d = '0;
        propModel = 16'hAAAA;
        expQ.delete();

        // Reset values
        #12;
        checkOutput("rst_tag_res", 32'(tag_res), 32'd0);
        checkOutput("rst_valid", 32'(tag_res_valid), 32'd0);
        checkOutput("rst_exc_req", 32'(exc_req), 32'd0);
        checkOutput("rst_exc_pc", exc_pc, 32'd0);
        readCheck("rst_prop", 2'd0, 32'h0000_AAAA);
        readCheck("rst_check", 2'd1, 32'h0);
        readCheck("rst_count", 2'd2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // OLD mode on class 5
        cfgWrite(2'd0, 32'h0); tick();
        applyStimulus(5, 1'b1, 1'b0, 1'b1, 32'h0); tick();
        checkOutput("old_no_exc", 32'(exc_req), 32'd0);

        // AND then CLEAR on class 0
        cfgWrite(2'd0, 32'h1); tick();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h4); tick();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h8); tick();
        cfgWrite(2'd0, 32'h3); tick();
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'hC); tick();

        // OR on the 4-bit instance
        cfgWrite(2'd0, 32'hAAAA); tick();
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h10);
        tag4_a = 4'hC; tag4_b = 4'hA;
        tick();
        checkOutput("tag4_or", 32'(tag_res4), 32'hE);
        checkOutput("tag4_valid", 32'(tag_res_valid4), 32'd1);

        // Address 3 writes ignored, check reg width limit
        cfgWrite(2'd3, 32'hFFFF_FFFF); tick();
        readCheck("addr3_write_ignored", 2'd0, 32'h0000_AAAA);
        cfgWrite(2'd1, 32'hFFFF_FFFF); tick();
        readCheck("check_width", 2'd1, 32'h00FF_FFFF);
        cfgWrite(2'd1, 32'h40); tick();
        readCheck("check_s1_cls2", 2'd1, 32'h40);

        // Trap behaviour
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h100); tick();
        checkOutput("trap1_req", 32'(exc_req), 32'd1);
        checkOutput("trap1_pc", exc_pc, 32'h100);
        readCheck("count1", 2'd2, 32'd1);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h104); tick();
        checkOutput("trap2_pc_first_wins", exc_pc, 32'h100);
        readCheck("count2", 2'd2, 32'd2);
        exc_ack = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h108); tick();
        checkOutput("ack_viol_req", 32'(exc_req), 32'd1);
        checkOutput("ack_viol_pc", exc_pc, 32'h108);
        readCheck("count3", 2'd2, 32'd3);
        exc_ack = 1'b1; tick();
        checkOutput("ack_clears_req", 32'(exc_req), 32'd0);
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 32'h10C); tick();
        checkOutput("s2_off_no_exc", 32'(exc_req), 32'd0);

        // Config write and op in the same cycle
        cfgWrite(2'd1, 32'h0); tick();
        cfgWrite(2'd1, 32'h40);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h200); tick();
        checkOutput("same_cycle_no_exc", 32'(exc_req), 32'd0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h204); tick();
        checkOutput("next_cycle_exc", 32'(exc_req), 32'd1);
        checkOutput("next_cycle_pc", exc_pc, 32'h204);
        exc_ack = 1'b1; tick();

        // Counter saturation
`ifdef DIFT_VIOLATION_LOG_EN
        force dut.cnt_q = 31'h7FFF_FFFE;
        #1;
        release dut.cnt_q;
        readCheck("count_preload", 2'd2, 32'h7FFF_FFFE);
`else
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        readCheck("count_preload", 2'd2, 32'hFFFF_FFFE);
`endif
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(i)); tick();
            readCheck("count_sat", 2'd2, 32'hFFFF_FFFF);
        end
        cfgWrite(2'd2, 32'h0); tick();
        readCheck("count_clear", 2'd2, 32'h0);
        exc_ack = 1'b1; tick();

        // Five violations, then drain the log
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'(i * 16)); tick();
        end
        exc_ack = 1'b1; tick();
`ifdef DIFT_VIOLATION_LOG_EN
        readCheck("log_ovf_count", 2'd2, 32'h8000_0005);
        for (int i = 1; i <= 4; i++) begin
            cfg_re = 1'b1;
            readCheck("log_pop", 2'd3, 32'(i * 16));
            tick();
        end
        cfg_re = 1'b1;
        readCheck("log_empty", 2'd3, 32'h0);
        tick();
        readCheck("log_empty_again", 2'd3, 32'h0);
`else
        readCheck("nolog_count", 2'd2, 32'd5);
        cfg_re = 1'b1;
        readCheck("nolog_addr3", 2'd3, 32'h0);
        tick();
        readCheck("nolog_count_after_re", 2'd2, 32'd5);
`endif

        // Asynchronous reset in the middle of activity
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h300); tick();
        checkOutput("pre_reset_req", 32'(exc_req), 32'd1);
        cfgWrite(2'd0, 32'h0);
        applyStimulus(5, 1'b0, 1'b0, 1'b1, 32'h304); tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tag", 32'(tag_res), 32'd0);
        checkOutput("mid_rst_valid", 32'(tag_res_valid), 32'd0);
        checkOutput("mid_rst_req", 32'(exc_req), 32'd0);
        checkOutput("mid_rst_pc", exc_pc, 32'h0);
        readCheck("mid_rst_prop", 2'd0, 32'h0000_AAAA);
        readCheck("mid_rst_check", 2'd1, 32'h0);
        readCheck("mid_rst_count", 2'd2, 32'h0);
        readCheck("mid_rst_log", 2'd3, 32'h0);
        propModel = 16'hAAAA;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 32'h500); tick();
        checkOutput("post_rst_no_exc", 32'(exc_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
